// File: rtl/gi_kctl.sv
// rtl/gi_kctl.sv - AES-128 decryption key buffer sequencer.
// Loads 11 expanded round keys, then rotates the buffer last-to-first once per block.
module gi_kctl (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       key_start,
    input  logic       kx_valid,
    output logic       kx_ready,
    output logic       kbuf_load,
    output logic       kbuf_shift,
    output logic       key_valid,
    input  logic       blk_start,
    input  logic       rnd_step,
    output logic       rk_valid,
    output logic [3:0] rnd,
    output logic       busy,
    output logic       blk_done,
    input  logic       abort,
    output logic       abort_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        READY  = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t     state;
    logic [3:0] lcnt;
    logic [3:0] rcnt;
    logic       abort_pend;

    assign kbuf_load  = kx_valid & kx_ready;
    assign kbuf_shift = rnd_step & rk_valid & (state == RUN);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= IDLE;
            lcnt       <= 4'd0;
            rcnt       <= 4'd0;
            abort_pend <= 1'b0;
            kx_ready   <= 1'b0;
            key_valid  <= 1'b0;
            rk_valid   <= 1'b0;
            rnd        <= LAST_IDX;
            busy       <= 1'b0;
            blk_done   <= 1'b0;
            abort_ack  <= 1'b0;
        end else begin
            blk_done  <= 1'b0;
            abort_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_start) begin
                        state    <= LOAD;
                        lcnt     <= 4'd0;
                        kx_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    // A partial key is useless; abort wins over a concurrent beat.
                    if (abort) begin
                        state     <= IDLE;
                        lcnt      <= 4'd0;
                        kx_ready  <= 1'b0;
                        abort_ack <= 1'b1;
                    end else if (kbuf_load) begin
                        if (lcnt == LAST_IDX) begin
                            state    <= SETTLE;
                            lcnt     <= 4'd0;
                            kx_ready <= 1'b0;
                        end else begin
                            lcnt <= lcnt + 4'd1;
                        end
                    end
                end
                SETTLE: begin
                    // Lets the buffer's registered strobe stage land before use.
                    state     <= READY;
                    key_valid <= 1'b1;
                    rk_valid  <= 1'b1;
                    rnd       <= LAST_IDX;
                end
                READY: begin
                    if (key_start) begin
                        state     <= LOAD;
                        lcnt      <= 4'd0;
                        kx_ready  <= 1'b1;
                        key_valid <= 1'b0;
                        rk_valid  <= 1'b0;
                    end else if (abort) begin
                        abort_ack <= 1'b1;
                    end else if (blk_start) begin
                        state <= RUN;
                        rcnt  <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (kbuf_shift) begin
                        rk_valid <= 1'b0;
                        if (rcnt == LAST_IDX) begin
                            // 11th shift: buffer is home, so a pended abort is safe now.
                            state     <= SETTLE;
                            rcnt      <= 4'd0;
                            rnd       <= LAST_IDX;
                            busy      <= 1'b0;
                            key_valid <= 1'b0;
                            blk_done  <= 1'b1;
                            if (abort_pend || abort) begin
                                abort_ack  <= 1'b1;
                                abort_pend <= 1'b0;
                            end
                        end else begin
                            rcnt <= rcnt + 4'd1;
                            rnd  <= 4'd9 - rcnt;
                        end
                    end else begin
                        rk_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gi_kctl.md
# gi_kctl

Sequencer for the AES decryption key buffer (the 11-entry circular shift register of expanded round keys). It accepts expanded round keys from the key expander and issues the buffer's load strobes. It then steps the buffer one round key per AES round while the decrypt core works through a 16-byte block, so round keys reach the core last-to-first. Aborts are honored only at block boundaries, so the buffer always rotates back to its home position.

## Interface
- No parameters (round count fixed at 11 keys, AES-128).
- clk  in  1  system clock
- reset_l  in  1  asynchronous active-low reset
- key_start  in  1  begin loading a new expanded key
- kx_valid  in  1  expander presents one round key on its data bus (bus goes straight to the key buffer)
- kx_ready  out  1  controller accepts expander words (high only in LOAD)
- kbuf_load  out  1  load strobe to key buffer; = kx_valid & kx_ready
- kbuf_shift  out  1  shift strobe to key buffer; = rnd_step & rk_valid & (state==RUN)
- key_valid  out  1  complete key resident and settled (READY or RUN)
- blk_start  in  1  core requests start of block decrypt
- rnd_step  in  1  core has consumed the current round key
- rk_valid  out  1  buffer output equals the key for round rnd
- rnd  out  4  round number of key on buffer output; 10 down to 0 in RUN, 10 otherwise
- busy  out  1  block in progress (RUN)
- blk_done  out  1  one-cycle pulse after the 11th step of a block
- abort  in  1  abort request
- abort_ack  out  1  one-cycle pulse when the abort is honored

## Operation
- States: IDLE, LOAD, SETTLE, READY, RUN. Counters: lcnt and rcnt, each 4 bits, range 0..10.
- IDLE: key_valid=0. key_start → LOAD with lcnt=0.
- LOAD: each kbuf_load increments lcnt. The load with lcnt==10 → SETTLE. abort → IDLE with abort_ack; the partial key is discarded.
- SETTLE: one cycle, always → READY. Covers the key buffer's one-cycle registered strobe stage.
- READY: key_valid=1, rk_valid=1.
  - key_start → LOAD; key_valid drops the next cycle.
  - Else abort → stays READY with abort_ack.
  - Else blk_start → RUN with rcnt=0.
- RUN: rnd = 10 − rcnt.
  - An accepted rnd_step pulses kbuf_shift. rk_valid goes to 0 for the following cycle, then back to 1. rcnt increments.
  - The step with rcnt==10 (11th shift, buffer back at home position) → SETTLE and pulses blk_done the next cycle.
  - abort in RUN sets abort_pend. The block continues to completion. abort_ack pulses together with blk_done, and abort_pend clears.
  - key_start and blk_start are ignored in RUN.
- Priority for simultaneous inputs in READY: key_start > abort > blk_start.
- rnd_step and abort in the same RUN cycle: the step is honored and the abort is pended.
- rnd_step while rk_valid=0, or outside RUN, is ignored.

## Timing
- Reset values: state IDLE, lcnt=rcnt=0, abort_pend=0, rnd=10. kx_ready, kbuf_load, kbuf_shift, key_valid, rk_valid, busy, blk_done, abort_ack are all 0.
- Reset mid-operation returns to IDLE at once. Buffer contents are treated as invalid, and a new key_start is required.
- kbuf_load and kbuf_shift are combinational from inputs and registered state. All other outputs are registered.
- Key load takes 11 accepted beats, at 1 beat/cycle best case. If the final load is in cycle n, the state is SETTLE in n+1 and key_valid=1 from n+2.
- If a step is accepted in cycle n, rk_valid=0 in n+1 and the new key is valid with rk_valid=1 from n+2.
- Minimum block with a core stepping every valid cycle:
  - 21 cycles from the first RUN cycle to the 11th step.
  - blk_done in the cycle after the 11th step (SETTLE).
  - Next blk_start accepted 2 cycles after the last step.

## Test plan
- Reset, key_start, 11 back-to-back kx_valid → exactly 11 kbuf_load pulses; key_valid rises 2 cycles after the last one; rnd=10.
- blk_start, then rnd_step held high → kbuf_shift every other cycle, rnd steps 10,9,…,0; 11 shifts total; blk_done once; then READY.
- abort asserted after the 4th step → steps continue to 11; abort_ack coincides with blk_done; rnd returns to 10.
- abort in the 6th load beat → IDLE, key_valid stays 0, abort_ack one pulse. key_start, blk_start, abort together in READY → LOAD only.
- reset_l low mid-RUN (rcnt=5) → all outputs to reset values asynchronously; blk_start ignored until a reload completes.
- Stalled expander (kx_valid toggling randomly) and stalled core (random rnd_step) → still exactly 11 loads and 11 shifts per block.
